// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 slave front end for the single-port RAM.
// Deserialises MOSI frames into rx_data and streams RAM read data on MISO.
module spi_slave_ctrl #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
);
    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(ADDR_SIZE);
    localparam logic [3:0] TX_REST  = 4'(ADDR_SIZE - 1);

    state_t               state;
    state_t               state_nx;
    logic                 rd_addr_done;
    logic                 frame_done;
    logic                 tx_wait;
    logic [3:0]           cnt;
    logic [3:0]           tx_left;
    logic [ADDR_SIZE:0]   rx_sh;
    logic [ADDR_SIZE-1:0] tx_sh;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (SS_n) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_nx = CHK_CMD;
                CHK_CMD: begin
                    if (!MOSI)
                        state_nx = WRITE;
                    else if (rd_addr_done)
                        state_nx = READ_DATA;
                    else
                        state_nx = READ_ADD;
                end
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_sh        <= '0;
            cnt          <= '0;
            frame_done   <= 1'b0;
            tx_wait      <= 1'b0;
            tx_sh        <= '0;
            tx_left      <= '0;
            MISO         <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_done <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n || state == IDLE) begin
                // rx_data and rd_addr_done survive an aborted frame
                rx_sh      <= '0;
                cnt        <= '0;
                frame_done <= 1'b0;
                tx_wait    <= 1'b0;
                tx_sh      <= '0;
                tx_left    <= '0;
                MISO       <= 1'b0;
            end else if (state == CHK_CMD) begin
                rx_sh <= {{ADDR_SIZE{1'b0}}, MOSI};
                cnt   <= '0;
            end else if (!frame_done) begin
                rx_sh <= {rx_sh[ADDR_SIZE-1:0], MOSI};
                cnt   <= cnt + 4'd1;
                if (cnt == LAST_BIT) begin
                    rx_data    <= {rx_sh, MOSI};
                    rx_valid   <= 1'b1;
                    frame_done <= 1'b1;
                    if (state == READ_ADD)
                        rd_addr_done <= 1'b1;
                    if (state == READ_DATA) begin
                        rd_addr_done <= 1'b0;
                        tx_wait      <= 1'b1;
                    end
                end
            end else if (tx_wait && tx_valid) begin
                tx_wait <= 1'b0;
                MISO    <= tx_data[ADDR_SIZE-1];
                tx_sh   <= {tx_data[ADDR_SIZE-2:0], 1'b0};
                tx_left <= TX_REST;
            end else if (tx_left != 4'd0) begin
                MISO    <= tx_sh[ADDR_SIZE-1];
                tx_sh   <= {tx_sh[ADDR_SIZE-2:0], 1'b0};
                tx_left <= tx_left - 4'd1;
            end else begin
                MISO <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Self-checking bench for spi_slave_ctrl.
// Frame-level reference model: whole frames in, expected strobes/MISO out.
module tb_spi_slave_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int errors = 0;
    int checks = 0;

    bit         m_rd_done;
    logic [9:0] m_rx_data;

    spi_slave_ctrl #(.ADDR_SIZE(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    // Runs one SS_n-low window of `low` edges followed by `hi` high edges.
    // Entered and left just after a falling edge.
    task automatic run_frame(input string nm, input logic [9:0] f,
                             input int low, input int hi, input bit ram,
                             input logic [7:0] txd, input bit extra);
        bit          complete;
        bit          rdata;
        logic [31:0] e_rxv;
        logic [31:0] e_miso;
        logic [31:0] o_rxv;
        logic [31:0] o_miso;
        logic [9:0]  e_rxd;
        int          rxd_bad;
        complete = (low >= 11);
        rdata    = complete && f[9] && m_rd_done;
        e_rxv    = '0;
        e_miso   = '0;
        o_rxv    = '0;
        o_miso   = '0;
        rxd_bad  = 0;
        if (complete)
            e_rxv[10] = 1'b1;
        if (rdata && ram)
            for (int b = 0; b < 8; b++)
                if (12 + b < low)
                    e_miso[12+b] = txd[7-b];
        SS_n     = 1'b0;
        MOSI     = 1'($urandom);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        for (int k = 0; k < low + hi; k++) begin
            @(negedge clk);
            o_rxv[k]  = rx_valid;
            o_miso[k] = MISO;
            e_rxd = (complete && k >= 10) ? f : m_rx_data;
            if (rx_data !== e_rxd)
                rxd_bad++;
            SS_n     = (k + 1 < low) ? 1'b0 : 1'b1;
            MOSI     = (k + 1 <= 10) ? f[9-k] : 1'($urandom);
            tx_valid = (ram && k + 1 == 12) || (extra && k + 1 == 14);
            tx_data  = (k + 1 == 12) ? txd : 8'($urandom);
        end
        if (complete) begin
            m_rx_data = f;
            if (f[9])
                m_rd_done = !m_rd_done;
        end
        checks++;
        if (o_rxv !== e_rxv) begin
            errors++;
            $display("FAIL %s rx_valid trace: got %h want %h", nm, o_rxv, e_rxv);
        end
        checks++;
        if (o_miso !== e_miso) begin
            errors++;
            $display("FAIL %s MISO trace: got %h want %h", nm, o_miso, e_miso);
        end
        checks++;
        if (rxd_bad !== 0) begin
            errors++;
            $display("FAIL %s rx_data: %0d bad cycles, now %h want %h",
                     nm, rxd_bad, rx_data, m_rx_data);
        end
        checks++;
        if (dut.rd_addr_done !== m_rd_done) begin
            errors++;
            $display("FAIL %s rd_addr_done: got %b want %b",
                     nm, dut.rd_addr_done, m_rd_done);
        end
    endtask

    task automatic test_reset;
        int seen;
        seen  = 0;
        rst_n = 1'b0;
        SS_n  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        for (int k = 0; k < 14; k++) begin
            MOSI = 1'($urandom);
            @(negedge clk);
            if (rx_valid !== 1'b0)
                seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_rx_valid: got %0d strobes want 0", seen);
        end
        checks++;
        if (MISO !== 1'b0) begin
            errors++;
            $display("FAIL reset_miso: got %b want 0", MISO);
        end
        checks++;
        if (rx_data !== 10'h000) begin
            errors++;
            $display("FAIL reset_rx_data: got %h want 000", rx_data);
        end
        checks++;
        if (dut.rd_addr_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd_done: got %b want 0", dut.rd_addr_done);
        end
        m_rd_done = 1'b0;
        m_rx_data = 10'h000;
        rst_n = 1'b1;
        SS_n  = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write;
        run_frame("wr_addr", 10'h035, 11, 1, 1'b0, 8'h00, 1'b0);
        run_frame("wr_data", 10'h1CA, 11, 2, 1'b1, 8'h5A, 1'b0);
    endtask

    task automatic test_read;
        run_frame("rd_addr", 10'h235, 11, 1, 1'b0, 8'h00, 1'b0);
        run_frame("rd_data", {2'b11, 8'($urandom)}, 20, 1, 1'b1, 8'hA5, 1'b1);
    endtask

    task automatic test_abort;
        run_frame("abort_wr", 10'h0B7, 6, 1, 1'b0, 8'h00, 1'b0);
        run_frame("after_abort", 10'h1F0, 11, 1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_abort_burst;
        run_frame("rd_addr2", 10'h2C3, 11, 1, 1'b0, 8'h00, 1'b0);
        run_frame("burst_abort", 10'h3FF, 15, 1, 1'b1, 8'hC6, 1'b0);
        run_frame("rd_via_add", 10'h31E, 20, 1, 1'b1, 8'h99, 1'b0);
    endtask

    task automatic test_reset_mid_frame;
        logic [9:0] f;
        int         seen;
        f    = {1'b0, 9'($urandom)};
        seen = 0;
        if (!m_rd_done)
            run_frame("pre_rd_addr", 10'h2AA, 11, 1, 1'b0, 8'h00, 1'b0);
        SS_n     = 1'b0;
        tx_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            MOSI = f[9-k];
        end
        @(negedge clk);
        MOSI  = f[5];
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({MISO, rx_valid} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_outputs: got miso=%b rxv=%b want 0 0",
                     MISO, rx_valid);
        end
        checks++;
        if (rx_data !== 10'h000) begin
            errors++;
            $display("FAIL midrst_rx_data: got %h want 000", rx_data);
        end
        checks++;
        if (dut.rd_addr_done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_rd_done: got %b want 0", dut.rd_addr_done);
        end
        rst_n = 1'b1;
        m_rd_done = 1'b0;
        m_rx_data = 10'h000;
        for (int k = 0; k < 7; k++) begin
            MOSI = 1'($urandom);
            SS_n = (k < 6) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (rx_valid !== 1'b0)
                seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midrst_no_strobe: got %0d strobes want 0", seen);
        end
        run_frame("after_midrst", 10'h1F0, 11, 1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [9:0] f;
        int         low;
        bit         ram;
        for (int i = 0; i < 40; i++) begin
            f   = 10'($urandom);
            low = ($urandom_range(0, 2) != 0) ? $urandom_range(11, 21)
                                              : $urandom_range(2, 12);
            ram = 1'($urandom);
            run_frame($sformatf("rand%0d", i), f, low, $urandom_range(1, 2),
                      ram, 8'($urandom), ram && 1'($urandom));
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        @(negedge clk);
        test_reset;
        test_write;
        test_read;
        test_abort;
        test_abort_burst;
        test_reset_mid_frame;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

SPI slave front-end that deserialises MOSI frames into 10-bit command/data words for the single-port RAM and serialises RAM read data back onto MISO. It sits directly upstream of the RAM: `rx_data`/`rx_valid` drive the RAM's `din`/`rx_valid`, and the RAM's `dout`/`tx_valid` return on `tx_data`/`tx_valid`. SPI mode 0: SCK is the system clock `clk`, MSB-first, one bit per clock.

## Interface
- `ADDR_SIZE`, default 8: RAM address/data width; frame width is ADDR_SIZE+2.
- `clk` input, 1 bit: system clock and SPI bit clock; all logic on posedge.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `SS_n` input, 1 bit: slave select, active-low; frame delimiter.
- `MOSI` input, 1 bit: serial data in, sampled on posedge.
- `MISO` output, 1 bit: serial data out, registered.
- `rx_data` output, ADDR_SIZE+2 bits: captured frame; [9:8] is the RAM command, [7:0] is the payload.
- `rx_valid` output, 1 bit: one-cycle strobe; `rx_data` is valid.
- `tx_data` input, ADDR_SIZE bits: RAM read data.
- `tx_valid` input, 1 bit: `tx_data` is valid; sampled only in READ_DATA after the frame strobe.

## Operation
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- Internal flag `rd_addr_done` is cleared by reset.
- IDLE: on `SS_n`=0 -> CHK_CMD. Otherwise stay.
- CHK_CMD:
  - Sample `MOSI` as frame bit 9.
  - `MOSI`=0 -> WRITE.
  - `MOSI`=1 and `rd_addr_done`=0 -> READ_ADD.
  - `MOSI`=1 and `rd_addr_done`=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift in bits 8..0 MSB-first with a 4-bit counter.
- After bit 0 is captured, `rx_valid` pulses once and `rx_data` holds the frame.
- READ_ADD frame completion sets `rd_addr_done`.
- READ_DATA frame completion clears `rd_addr_done`, then waits for `tx_valid`=1.
  - On the first sampled `tx_valid`, load `tx_data` into the output shifter.
  - Drive 8 bits on MISO, MSB-first, one per clock. MISO returns to 0 afterwards.
- Frame-bit semantics: commands 00/01 are written as sent. The block does not check frame bit 8 against the state; the RAM decodes `rx_data[9:8]`.
- After the frame (and the MISO burst for READ_DATA), remain in the current state, ignoring MOSI, until `SS_n`=1.
- `SS_n`=1 in any state -> IDLE on that edge.
  - Aborts the shift and counter; no `rx_valid` for a partial frame.
  - Stops MISO mid-burst; MISO goes to 0.
  - `rd_addr_done` is unaffected by the abort.
- Reset dominates everything and takes effect on the edge it is sampled.

## Timing
- Reset values:
  - State IDLE, `rd_addr_done`=0.
  - `MISO`=0, `rx_valid`=0, `rx_data`=0.
  - Shifter and counter 0.
- Let edge E0 be the edge that samples `SS_n`=0 in IDLE.
  - E1 samples bit 9.
  - E2..E10 sample bits 8..0.
  - `rx_valid`=1 during the cycle after E10 only; `rx_data` is stable from E10 until the next frame completes.
- Minimum frame: 11 clocks of `SS_n` low.
- Read path:
  - RAM asserts `tx_valid` one cycle after `rx_valid`.
  - The edge sampling `tx_valid`=1 (E_t) sets MISO = `tx_data[7]`.
  - E_t+1..E_t+7 present bits 6..0.
  - E_t+8 sets MISO=0.
  - Total: 11 + 1 (RAM) + 8 clocks of `SS_n` low.
- `tx_valid` outside the READ_DATA wait window is ignored.
- A second `tx_valid` during the burst is ignored.
- Back-to-back frames need `SS_n` high for at least 1 sampled edge.
- `SS_n` going low on the same edge the FSM enters IDLE is acted on at the next edge.

## Test plan
- Write address, then write data: `SS_n` low, MOSI = 00_0011_0101 -> `rx_valid` pulse after the 11th edge with `rx_data`=0x035. Then MOSI = 01_1100_1010 -> `rx_data`=0x1CA. MISO stays 0 throughout.
- Read address: MOSI = 10_0011_0101 -> `rx_data`=0x235, and `rd_addr_done` goes 1.
- Read data: the next frame MOSI = 11_xxxx_xxxx with the RAM model returning `tx_data`=0xA5 one cycle after `rx_valid` -> `rx_data[9:8]`=11. MISO sequence is 1,0,1,0,0,1,0,1, then 0, and `rd_addr_done` goes 0.
- Abort: `SS_n` raised after 5 bits of a write frame -> no `rx_valid`, state returns to IDLE. A following full frame 01_1111_0000 -> `rx_data`=0x1F0.
- Abort mid-read-burst: `SS_n` raised after 3 MISO bits -> MISO goes 0 the next edge. A following read-data frame with `rd_addr_done`=0 goes through READ_ADD.
- Reset mid-frame: `rst_n`=0 for 1 edge during bit 4 of a frame -> all outputs 0, state IDLE, `rd_addr_done` 0, and no `rx_valid` is produced.
